pc_seq_ctrl: RTL and testbench
==============================

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; synchronous, active-low (0 = reset), sampled on rising clk.
REQ-003 SHALL have port op_class, input, 3; decoded instruction class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JREG, 6 ERET, 7 NOP.
REQ-004 SHALL have port br_taken, input, 1; branch condition from the ALU, valid in DECODE.
REQ-005 SHALL have port irq, input, 1; level-sensitive external interrupt request.
REQ-006 SHALL have port ie, input, 1; global interrupt enable from CP0.
REQ-007 SHALL have port PCWr, output, 1; PC write enable to the fetch unit.
REQ-008 SHALL have port NPCSel, output, 3; next-PC select using the shared NPC_SEL_* codes.
REQ-009 SHALL have port RegPCSrc, output, 1; register-jump target: 0 GPR rs, 1 EPC.
REQ-010 SHALL have ports IRWr, RegWr, MemWr, EPCWr, EXLSet, EXLClr, int_ack, output, 1 each; one-cycle strobes.
REQ-011 SHALL have port state, output, 3; current FSM state for debug.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXE, MEM, LDWB, WB, INT, encoded 0-6.
REQ-013 In FETCH: IRWr=1, PCWr=1, NPCSel=NPC_SEL_PC_ADD_4; next DECODE.
REQ-014 In DECODE by op_class: ALU->EXE; LOAD/STORE->MEM; NOP or 7->instruction end.
REQ-015 In DECODE, BRANCH: PCWr=br_taken, NPCSel=NPC_SEL_BEQ_JMP; then instruction end.
REQ-016 In DECODE, JUMP: PCWr=1, NPCSel=NPC_SEL_J_JMP; then instruction end.
REQ-017 In DECODE, JREG: PCWr=1, NPCSel=NPC_SEL_REG_JMP, RegPCSrc=0; then instruction end.
REQ-018 In DECODE, ERET: PCWr=1, NPCSel=NPC_SEL_REG_JMP, RegPCSrc=1, EXLClr=1; then instruction end.
REQ-019 EXE->WB. MEM: STORE drives MemWr=1 and goes to instruction end; LOAD goes to LDWB. LDWB->WB. WB: RegWr=1, then instruction end.
REQ-020 Instruction end SHALL go to INT if irq&ie&~exl, else FETCH; exl is an internal flag.
REQ-021 In INT: EPCWr=1, EXLSet=1, PCWr=1, NPCSel=NPC_SEL_INT_JMP, int_ack=1 for exactly one cycle; next FETCH.
REQ-022 exl SHALL set on the INT cycle and clear on the ERET DECODE cycle; it blocks nested interrupts.
REQ-023 EPC SHALL capture the PC present during INT, i.e. the address of the next unexecuted instruction, including any taken branch or jump target.
REQ-024 An irq arriving mid-instruction SHALL NOT abort it; irq is sampled only at instruction end.
REQ-025 All strobes not listed for a state SHALL be 0; NPCSel SHALL default to NPC_SEL_PC_ADD_4.
REQ-026 Outputs SHALL be Moore/Mealy from the current state and inputs, with zero added latency.

Reset
REQ-027 reset=0 at a clk edge SHALL force state=FETCH and exl=0, overriding every other condition, including mid-instruction and during INT.
REQ-028 While reset=0, all strobes SHALL be 0.

Configuration
REQ-029 Macro PC_SEQ_INT_EN defined: interrupt path enabled (INT state, exl, EPCWr/EXLSet/EXLClr/int_ack active).
REQ-030 PC_SEQ_INT_EN undefined: instruction end always goes to FETCH; ERET is treated as NOP; EPCWr, EXLSet, EXLClr, int_ack and RegPCSrc are tied to 0.

Structure
REQ-031 NPC_SEL_* codes, op_class codes and state encodings SHALL live in the shared macro header.
REQ-032 SHALL be a single module; the next-state/output decode MAY be split into sub-module pc_seq_decode.

Verification
REQ-033 Release reset, op_class=0 (ALU): states 0,1,2,5,0; RegWr=1 only in WB; PCWr=1 only in FETCH.
REQ-034 op_class=3, br_taken=1: DECODE shows PCWr=1, NPCSel=BEQ; with br_taken=0, PCWr=0.
REQ-035 op_class=1 (LOAD) with irq=1, ie=1 raised in MEM: sequence 0,1,3,4,5,6; INT shows int_ack=1, NPCSel=INT for one cycle; then 0.
REQ-036 With exl set, irq=1 held: no INT; ERET drives EXLClr=1 and RegPCSrc=1; the next instruction end enters INT.
REQ-037 reset=0 asserted in EXE: next state=0 and all strobes 0; with PC_SEQ_INT_EN undefined, irq=1, ie=1 never reaches state 6.

Source files
------------

// File: rtl/pc_seq_ctrl_pkg.sv
// ============================================================================
// Module      : pc_seq_ctrl_pkg
// Description : Shared encodings for the PC sequencing controller: FSM states,
//               op_class codes, NPC_SEL_* next-PC codes and the strobe bundle.
//               Define PC_SEQ_INT_EN to enable the interrupt/EPC/EXL path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_ctrl_pkg;

`ifdef PC_SEQ_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXE    = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_LDWB   = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_INT    = 3'd6;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_JREG   = 3'd5;
    localparam logic [2:0] OP_ERET   = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;

    localparam logic [2:0] NPC_SEL_PC_ADD_4 = 3'd0;
    localparam logic [2:0] NPC_SEL_BEQ_JMP  = 3'd1;
    localparam logic [2:0] NPC_SEL_J_JMP    = 3'd2;
    localparam logic [2:0] NPC_SEL_REG_JMP  = 3'd3;
    localparam logic [2:0] NPC_SEL_INT_JMP  = 3'd4;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       reg_pc_src;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic       epc_wr;
        logic       exl_set;
        logic       exl_clr;
        logic       int_ack;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_wr: 1'b0, npc_sel: NPC_SEL_PC_ADD_4, reg_pc_src: 1'b0,
        ir_wr: 1'b0, reg_wr: 1'b0, mem_wr: 1'b0, epc_wr: 1'b0,
        exl_set: 1'b0, exl_clr: 1'b0, int_ack: 1'b0
    };

endpackage

`default_nettype wire

// File: rtl/pc_seq_decode.sv
// ============================================================================
// Module      : pc_seq_decode
// Description : Combinational next-state and strobe decode for pc_seq_ctrl.
//               Interrupt behaviour follows PC_SEQ_INT_EN via pc_seq_ctrl_pkg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_decode
    import pc_seq_ctrl_pkg::*;
(
    input  logic        i_rst_n,
    input  logic [2:0]  i_state,
    input  logic [2:0]  i_op_class,
    input  logic        i_br_taken,
    input  logic        i_irq,
    input  logic        i_ie,
    input  logic        i_exl,
    output logic [2:0]  o_state_nxt,
    output logic        o_exl_nxt,
    output ctrl_t       o_ctrl
);

    logic [2:0] w_end_state;

    // irq is only looked at here, so an in-flight instruction always completes
    assign w_end_state = (INT_EN && i_irq && i_ie && !i_exl) ? ST_INT : ST_FETCH;

    always_comb begin
        o_ctrl      = CTRL_IDLE;
        o_state_nxt = ST_FETCH;
        o_exl_nxt   = i_exl;

        case (i_state)
            ST_FETCH: begin
                o_ctrl.ir_wr = 1'b1;
                o_ctrl.pc_wr = 1'b1;
                o_state_nxt  = ST_DECODE;
            end
            ST_DECODE: begin
                case (i_op_class)
                    OP_ALU:   o_state_nxt = ST_EXE;
                    OP_LOAD,
                    OP_STORE: o_state_nxt = ST_MEM;
                    OP_BRANCH: begin
                        o_ctrl.pc_wr   = i_br_taken;
                        o_ctrl.npc_sel = NPC_SEL_BEQ_JMP;
                        o_state_nxt    = w_end_state;
                    end
                    OP_JUMP: begin
                        o_ctrl.pc_wr   = 1'b1;
                        o_ctrl.npc_sel = NPC_SEL_J_JMP;
                        o_state_nxt    = w_end_state;
                    end
                    OP_JREG: begin
                        o_ctrl.pc_wr   = 1'b1;
                        o_ctrl.npc_sel = NPC_SEL_REG_JMP;
                        o_state_nxt    = w_end_state;
                    end
                    OP_ERET: begin
                        // Without the interrupt path ERET degenerates to a NOP
                        if (INT_EN) begin
                            o_ctrl.pc_wr      = 1'b1;
                            o_ctrl.npc_sel    = NPC_SEL_REG_JMP;
                            o_ctrl.reg_pc_src = 1'b1;
                            o_ctrl.exl_clr    = 1'b1;
                            o_exl_nxt         = 1'b0;
                        end
                        o_state_nxt = w_end_state;
                    end
                    default:  o_state_nxt = w_end_state;
                endcase
            end
            ST_EXE:  o_state_nxt = ST_WB;
            ST_MEM: begin
                if (i_op_class == OP_STORE) begin
                    o_ctrl.mem_wr = 1'b1;
                    o_state_nxt   = w_end_state;
                end else begin
                    o_state_nxt   = ST_LDWB;
                end
            end
            ST_LDWB: o_state_nxt = ST_WB;
            ST_WB: begin
                o_ctrl.reg_wr = 1'b1;
                o_state_nxt   = w_end_state;
            end
            ST_INT: begin
                if (INT_EN) begin
                    o_ctrl.epc_wr  = 1'b1;
                    o_ctrl.exl_set = 1'b1;
                    o_ctrl.pc_wr   = 1'b1;
                    o_ctrl.npc_sel = NPC_SEL_INT_JMP;
                    o_ctrl.int_ack = 1'b1;
                    o_exl_nxt      = 1'b1;
                end
                o_state_nxt = ST_FETCH;
            end
            default: o_state_nxt = ST_FETCH;
        endcase

        if (!i_rst_n) begin
            o_ctrl      = CTRL_IDLE;
            o_state_nxt = ST_FETCH;
            o_exl_nxt   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Multi-cycle PC sequencing FSM with optional interrupt entry
//               (enable with macro PC_SEQ_INT_EN). Synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op_class,
    input  logic        br_taken,
    input  logic        irq,
    input  logic        ie,
    output logic        PCWr,
    output logic [2:0]  NPCSel,
    output logic        RegPCSrc,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic        EPCWr,
    output logic        EXLSet,
    output logic        EXLClr,
    output logic        int_ack,
    output logic [2:0]  state
);

    logic [2:0] r_state;
    logic       r_exl;
    logic [2:0] w_state_nxt;
    logic       w_exl_nxt;
    ctrl_t      w_ctrl;

    pc_seq_decode u_decode (
        .i_rst_n     (reset),
        .i_state     (r_state),
        .i_op_class  (op_class),
        .i_br_taken  (br_taken),
        .i_irq       (irq),
        .i_ie        (ie),
        .i_exl       (r_exl),
        .o_state_nxt (w_state_nxt),
        .o_exl_nxt   (w_exl_nxt),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_exl   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exl   <= w_exl_nxt;
        end
    end

    assign PCWr     = w_ctrl.pc_wr;
    assign NPCSel   = w_ctrl.npc_sel;
    assign RegPCSrc = w_ctrl.reg_pc_src;
    assign IRWr     = w_ctrl.ir_wr;
    assign RegWr    = w_ctrl.reg_wr;
    assign MemWr    = w_ctrl.mem_wr;
    assign EPCWr    = w_ctrl.epc_wr;
    assign EXLSet   = w_ctrl.exl_set;
    assign EXLClr   = w_ctrl.exl_clr;
    assign int_ack  = w_ctrl.int_ack;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// ============================================================================
// Module      : tb_pc_seq_ctrl
// Description : Directed self-checking bench for pc_seq_ctrl; interrupt
//               scenarios are built only when PC_SEQ_INT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] op_class = 3'd0;
    logic       br_taken = 1'b0;
    logic       irq = 1'b0;
    logic       ie = 1'b0;

    logic       PCWr, RegPCSrc, IRWr, RegWr, MemWr, EPCWr, EXLSet, EXLClr, int_ack;
    logic [2:0] NPCSel, state;
    logic [8:0] w_strb;

    int n_tests = 0;
    int n_fail  = 0;

    assign w_strb = {PCWr, IRWr, RegWr, MemWr, EPCWr, EXLSet, EXLClr, int_ack, RegPCSrc};

    pc_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op_class (op_class),
        .br_taken (br_taken),
        .irq      (irq),
        .ie       (ie),
        .PCWr     (PCWr),
        .NPCSel   (NPCSel),
        .RegPCSrc (RegPCSrc),
        .IRWr     (IRWr),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .EPCWr    (EPCWr),
        .EXLSet   (EXLSet),
        .EXLClr   (EXLClr),
        .int_ack  (int_ack),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op_class = 3'd0;
        tick();
        tick();
        n_tests++;
        if (state !== 3'd0 || w_strb !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d strobes=%b, want state=0 strobes=000000000", state, w_strb);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd0 || PCWr !== 1'b1 || IRWr !== 1'b1 || NPCSel !== 3'd0) begin
            n_fail++;
            $display("FAIL fetch_out: state=%0d PCWr=%b IRWr=%b NPCSel=%0d, want 0 1 1 0", state, PCWr, IRWr, NPCSel);
        end
    endtask

    task automatic test_alu();
        logic [2:0] es [5] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd0};
        logic       er [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       ep [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op_class = 3'd0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_tests++;
            if (state !== es[i] || RegWr !== er[i] || PCWr !== ep[i]) begin
                n_fail++;
                $display("FAIL alu[%0d]: state=%0d RegWr=%b PCWr=%b, want %0d %b %b",
                         i, state, RegWr, PCWr, es[i], er[i], ep[i]);
            end
        end
    endtask

    task automatic test_branch();
        op_class = 3'd3;
        br_taken = 1'b1;
        tick();
        n_tests++;
        if (state !== 3'd1 || PCWr !== 1'b1 || NPCSel !== 3'd1) begin
            n_fail++;
            $display("FAIL br_taken: state=%0d PCWr=%b NPCSel=%0d, want 1 1 1", state, PCWr, NPCSel);
        end
        br_taken = 1'b0;
        #1;
        n_tests++;
        if (PCWr !== 1'b0 || NPCSel !== 3'd1) begin
            n_fail++;
            $display("FAIL br_not_taken: PCWr=%b NPCSel=%0d, want 0 1", PCWr, NPCSel);
        end
        tick();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL br_end: state=%0d, want 0", state);
        end
    endtask

    task automatic test_jumps();
        op_class = 3'd4;
        tick();
        n_tests++;
        if (PCWr !== 1'b1 || NPCSel !== 3'd2 || RegPCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL jump: PCWr=%b NPCSel=%0d RegPCSrc=%b, want 1 2 0", PCWr, NPCSel, RegPCSrc);
        end
        tick();
        op_class = 3'd5;
        tick();
        n_tests++;
        if (state !== 3'd1 || PCWr !== 1'b1 || NPCSel !== 3'd3 || RegPCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL jreg: state=%0d PCWr=%b NPCSel=%0d RegPCSrc=%b, want 1 1 3 0", state, PCWr, NPCSel, RegPCSrc);
        end
        tick();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL jreg_end: state=%0d, want 0", state);
        end
    endtask

    task automatic test_mem();
        op_class = 3'd2;
        tick();
        tick();
        n_tests++;
        if (state !== 3'd3 || MemWr !== 1'b1 || RegWr !== 1'b0) begin
            n_fail++;
            $display("FAIL store_mem: state=%0d MemWr=%b RegWr=%b, want 3 1 0", state, MemWr, RegWr);
        end
        tick();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL store_end: state=%0d, want 0", state);
        end
        op_class = 3'd1;
        tick();
        tick();
        n_tests++;
        if (state !== 3'd3 || MemWr !== 1'b0) begin
            n_fail++;
            $display("FAIL load_mem: state=%0d MemWr=%b, want 3 0", state, MemWr);
        end
        tick();
        tick();
        n_tests++;
        if (state !== 3'd5 || RegWr !== 1'b1) begin
            n_fail++;
            $display("FAIL load_wb: state=%0d RegWr=%b, want 5 1", state, RegWr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        op_class = 3'd0;
        tick();
        tick();
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_exe: state=%0d, want 2", state);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (state !== 3'd0 || w_strb !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid: state=%0d strobes=%b, want 0 000000000", state, w_strb);
        end
        reset = 1'b1;
        #1;
    endtask

`ifdef PC_SEQ_INT_EN
    task automatic test_interrupt();
        logic [2:0] seq [4] = '{3'd1, 3'd2, 3'd5, 3'd0};
        op_class = 3'd1;
        irq = 1'b0;
        ie = 1'b0;
        tick();
        tick();
        irq = 1'b1;
        ie = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd3 || int_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_in_mem: state=%0d int_ack=%b, want 3 0", state, int_ack);
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (state !== 3'd6 || int_ack !== 1'b1 || NPCSel !== 3'd4 || EPCWr !== 1'b1
            || EXLSet !== 1'b1 || PCWr !== 1'b1) begin
            n_fail++;
            $display("FAIL int_state: state=%0d int_ack=%b NPCSel=%0d EPCWr=%b EXLSet=%b PCWr=%b, want 6 1 4 1 1 1",
                     state, int_ack, NPCSel, EPCWr, EXLSet, PCWr);
        end
        tick();
        n_tests++;
        if (state !== 3'd0 || int_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL int_exit: state=%0d int_ack=%b, want 0 0", state, int_ack);
        end
        // exl now set: an ALU instruction with irq held must end in FETCH
        op_class = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (state !== seq[i]) begin
                n_fail++;
                $display("FAIL exl_block[%0d]: state=%0d, want %0d", i, state, seq[i]);
            end
        end
        op_class = 3'd6;
        tick();
        n_tests++;
        if (EXLClr !== 1'b1 || RegPCSrc !== 1'b1 || PCWr !== 1'b1 || NPCSel !== 3'd3) begin
            n_fail++;
            $display("FAIL eret: EXLClr=%b RegPCSrc=%b PCWr=%b NPCSel=%0d, want 1 1 1 3", EXLClr, RegPCSrc, PCWr, NPCSel);
        end
        tick();
        op_class = 3'd7;
        tick();
        tick();
        n_tests++;
        if (state !== 3'd6) begin
            n_fail++;
            $display("FAIL post_eret_int: state=%0d, want 6", state);
        end
        irq = 1'b0;
        ie = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_interrupt();
        int hit6 = 0;
        irq = 1'b1;
        ie = 1'b1;
        op_class = 3'd6;
        tick();
        n_tests++;
        if (state !== 3'd1 || w_strb !== 9'd0 || NPCSel !== 3'd0) begin
            n_fail++;
            $display("FAIL eret_as_nop: state=%0d strobes=%b NPCSel=%0d, want 1 000000000 0", state, w_strb, NPCSel);
        end
        op_class = 3'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (state === 3'd6 || int_ack !== 1'b0) hit6++;
        end
        n_tests++;
        if (hit6 != 0) begin
            n_fail++;
            $display("FAIL no_int: entered INT/int_ack %0d times, want 0", hit6);
        end
        irq = 1'b0;
        ie = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jumps();
        test_mem();
`ifdef PC_SEQ_INT_EN
        test_interrupt();
`else
        test_no_interrupt();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
